// File: rtl/operand_fetch.sv
// Operand-fetch pipeline stage: scoreboarded hazard check, writeback bypass,
// and a single output slot with valid/ready handshaking on both sides.
module operand_fetch #(
  parameter int AW  = 6,
  parameter int DW  = 32,
  parameter int OPW = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [AW-1:0]     IN_SRA,
  input  logic [AW-1:0]     IN_SRB,
  input  logic [AW-1:0]     IN_DR,
  input  logic              IN_WEN,
  input  logic [OPW-1:0]    IN_OP,
  output logic [AW-1:0]     SRA,
  output logic [AW-1:0]     SRB,
  input  logic [DW-1:0]     RE_A,
  input  logic [DW-1:0]     RE_B,
  input  logic              WB_EN,
  input  logic [AW-1:0]     WB_DR,
  input  logic [DW-1:0]     WB_WD,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DW-1:0]     OUT_A,
  output logic [DW-1:0]     OUT_B,
  output logic [AW-1:0]     OUT_DR,
  output logic              OUT_WEN,
  output logic [OPW-1:0]    OUT_OP,
  output logic [2**AW-1:0]  BUSY_MASK
);

  localparam int NR = 2**AW;

  logic [NR-1:0]  busy_q, busy_d;
  logic           valid_q, valid_d;
  logic [DW-1:0]  a_q, a_d, b_q, b_d;
  logic [AW-1:0]  dr_q, dr_d;
  logic           wen_q, wen_d;
  logic [OPW-1:0] op_q, op_d;

  logic wb_hit_a, wb_hit_b, wb_hit_dr;
  logic haz_a, haz_b, waw;
  logic slot_free, ready, issue;

  assign SRA = IN_SRA;
  assign SRB = IN_SRB;

  // A writeback landing this cycle resolves a pending register, so it neither stalls nor is read stale.
  assign wb_hit_a  = WB_EN && (WB_DR == IN_SRA);
  assign wb_hit_b  = WB_EN && (WB_DR == IN_SRB);
  assign wb_hit_dr = WB_EN && (WB_DR == IN_DR);
  assign haz_a     = busy_q[IN_SRA] && !wb_hit_a;
  assign haz_b     = busy_q[IN_SRB] && !wb_hit_b;
  assign waw       = IN_WEN && busy_q[IN_DR] && !wb_hit_dr;

  assign slot_free = !valid_q || OUT_READY;
  assign ready     = !RST && slot_free && !haz_a && !haz_b && !waw;
  assign issue     = IN_VALID && ready;
  assign IN_READY  = ready;

  always_comb begin
    busy_d = busy_q;
    if (WB_EN) begin
      busy_d[WB_DR] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    // Set is applied after clear so a same-register set/clear ends pending.
    if (issue && IN_WEN) begin
      busy_d[IN_DR] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    dr_d    = dr_q;
    wen_d   = wen_q;
    op_d    = op_q;
    if (issue) begin
      valid_d = 1'b1;
      a_d     = wb_hit_a ? WB_WD : RE_A;
      b_d     = wb_hit_b ? WB_WD : RE_B;
      dr_d    = IN_DR;
      wen_d   = IN_WEN;
      op_d    = IN_OP;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q  <= '0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      dr_q    <= '0;
      wen_q   <= 1'b0;
      op_q    <= '0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dr_q    <= dr_d;
      wen_q   <= wen_d;
      op_q    <= op_d;
    end
  end

  assign OUT_VALID = valid_q;
  assign OUT_A     = a_q;
  assign OUT_B     = b_q;
  assign OUT_DR    = dr_q;
  assign OUT_WEN   = wen_q;
  assign OUT_OP    = op_q;
  assign BUSY_MASK = busy_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: stimulus pushes expected bundles into a
// scoreboard queue, a monitor pops and compares on each output handshake.
module tb_operand_fetch;

  localparam int AW = 6, DW = 32, OPW = 8;

  logic CLK = 1'b0, RST = 1'b1;
  logic IN_VALID = 1'b0, IN_READY;
  logic [AW-1:0] IN_SRA = '0, IN_SRB = '0, IN_DR = '0, SRA, SRB, WB_DR = '0, OUT_DR;
  logic IN_WEN = 1'b0, WB_EN = 1'b0, OUT_VALID, OUT_READY = 1'b0, OUT_WEN;
  logic [OPW-1:0] IN_OP = '0, OUT_OP;
  logic [DW-1:0] RE_A = '0, RE_B = '0, WB_WD = '0, OUT_A, OUT_B;
  logic [2**AW-1:0] BUSY_MASK;

  typedef struct {
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [AW-1:0]  dr;
    logic           wen;
    logic [OPW-1:0] op;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  operand_fetch #(.AW(AW), .DW(DW), .OPW(OPW)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_SRA(IN_SRA), .IN_SRB(IN_SRB), .IN_DR(IN_DR), .IN_WEN(IN_WEN), .IN_OP(IN_OP),
    .SRA(SRA), .SRB(SRB), .RE_A(RE_A), .RE_B(RE_B),
    .WB_EN(WB_EN), .WB_DR(WB_DR), .WB_WD(WB_WD),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_A(OUT_A), .OUT_B(OUT_B),
    .OUT_DR(OUT_DR), .OUT_WEN(OUT_WEN), .OUT_OP(OUT_OP), .BUSY_MASK(BUSY_MASK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] sra, input logic [AW-1:0] srb,
                       input logic [AW-1:0] dr, input logic wen, input logic [OPW-1:0] op,
                       input logic [DW-1:0] ra, input logic [DW-1:0] rb);
    IN_VALID = 1'b1; IN_SRA = sra; IN_SRB = srb; IN_DR = dr;
    IN_WEN = wen; IN_OP = op; RE_A = ra; RE_B = rb;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [AW-1:0] dr, input logic wen, input logic [OPW-1:0] op);
    exp_t e;
    e.a = a; e.b = b; e.dr = dr; e.wen = wen; e.op = op;
    sb.push_back(e);
  endtask

  // Monitor: every accepted output bundle must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && OUT_VALID && OUT_READY) begin
        if (sb.size() == 0) begin
          chk("unexpected_bundle", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("out_a", 64'(OUT_A), 64'(e.a));
          chk("out_b", 64'(OUT_B), 64'(e.b));
          chk("out_dr", 64'(OUT_DR), 64'(e.dr));
          chk("out_wen", 64'(OUT_WEN), 64'(e.wen));
          chk("out_op", 64'(OUT_OP), 64'(e.op));
        end
      end
    end
  end

  initial begin
    #3;
    chk("rst_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_busy", 64'(BUSY_MASK), 64'd0);
    chk("rst_ready", 64'(IN_READY), 64'd0);
    chk("rst_outa", 64'(OUT_A), 64'd0);
    step();
    RST = 1'b0;

    // Basic issue in the first cycle after reset release.
    OUT_READY = 1'b1;
    drive(6'd3, 6'd4, 6'd5, 1'b1, 8'h10, 32'h11, 32'h22);
    @(negedge CLK);
    chk("basic_ready", 64'(IN_READY), 64'd1);
    push(32'h11, 32'h22, 6'd5, 1'b1, 8'h10);
    step();
    chk("basic_valid", 64'(OUT_VALID), 64'd1);
    chk("basic_busy", 64'(BUSY_MASK), 64'h20);

    // RAW stall on r5, then writeback bypass.
    drive(6'd5, 6'd1, 6'd6, 1'b0, 8'h20, 32'hDEAD, 32'h33);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("raw_stall", 64'(IN_READY), 64'd0);
      step();
    end
    chk("raw_no_issue", 64'(OUT_VALID), 64'd0);
    WB_EN = 1'b1; WB_DR = 6'd5; WB_WD = 32'hCAFE;
    @(negedge CLK);
    chk("raw_bypass_ready", 64'(IN_READY), 64'd1);
    push(32'hCAFE, 32'h33, 6'd6, 1'b0, 8'h20);
    step();
    WB_EN = 1'b0;
    chk("raw_busy_clear", 64'(BUSY_MASK), 64'd0);

    // Backpressure: bundle must hold while OUT_READY is low.
    OUT_READY = 1'b0;
    drive(6'd1, 6'd2, 6'd9, 1'b1, 8'h30, 32'h44, 32'h55);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("bp_ready", 64'(IN_READY), 64'd0);
      chk("bp_hold_a", 64'(OUT_A), 64'hCAFE);
      chk("bp_hold_valid", 64'(OUT_VALID), 64'd1);
      chk("bp_hold_dr", 64'(OUT_DR), 64'd6);
      step();
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("bp_release_ready", 64'(IN_READY), 64'd1);
    push(32'h44, 32'h55, 6'd9, 1'b1, 8'h30);
    step();

    // r7 pending via an instruction with identical sources.
    drive(6'd0, 6'd0, 6'd7, 1'b1, 8'h40, 32'h66, 32'h66);
    @(negedge CLK);
    chk("same_src_ready", 64'(IN_READY), 64'd1);
    push(32'h66, 32'h66, 6'd7, 1'b1, 8'h40);
    step();

    // WAW stall on r7, then issue alongside a writeback clearing r7.
    drive(6'd2, 6'd3, 6'd7, 1'b1, 8'h50, 32'h77, 32'h88);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("waw_stall", 64'(IN_READY), 64'd0);
      step();
    end
    WB_EN = 1'b1; WB_DR = 6'd7; WB_WD = 32'h99;
    @(negedge CLK);
    chk("waw_ready", 64'(IN_READY), 64'd1);
    push(32'h77, 32'h88, 6'd7, 1'b1, 8'h50);
    step();
    chk("set_wins", 64'(BUSY_MASK), 64'h280);

    // Writeback to an idle register is harmless; idle slot drains.
    IN_VALID = 1'b0; WB_DR = 6'd12;
    step();
    chk("harmless_wb", 64'(BUSY_MASK), 64'h280);
    WB_DR = 6'd9;
    step();
    WB_EN = 1'b0;
    chk("drain_valid", 64'(OUT_VALID), 64'd0);
    chk("clear_r9", 64'(BUSY_MASK), 64'h80);

    // Self-dependent instruction on a free r5, held under backpressure.
    OUT_READY = 1'b0;
    drive(6'd5, 6'd5, 6'd5, 1'b1, 8'h60, 32'hAA, 32'hBB);
    @(negedge CLK);
    chk("self_dep_ready", 64'(IN_READY), 64'd1);
    push(32'hAA, 32'hBB, 6'd5, 1'b1, 8'h60);
    step();
    chk("pre_rst_busy", 64'(BUSY_MASK), 64'hA0);
    chk("pre_rst_valid", 64'(OUT_VALID), 64'd1);

    // Asynchronous reset between edges discards the held bundle.
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(OUT_VALID), 64'd0);
    chk("mid_rst_busy", 64'(BUSY_MASK), 64'd0);
    chk("mid_rst_ready", 64'(IN_READY), 64'd0);
    sb.delete();
    step();
    chk("rst_hold_ready", 64'(IN_READY), 64'd0);
    RST = 1'b0;
    OUT_READY = 1'b1;
    drive(6'd7, 6'd5, 6'd3, 1'b0, 8'h70, 32'h1, 32'h2);
    @(negedge CLK);
    chk("post_rst_ready", 64'(IN_READY), 64'd1);
    push(32'h1, 32'h2, 6'd3, 1'b0, 8'h70);
    step();
    IN_VALID = 1'b0;
    step();
    step();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("final_busy", 64'(BUSY_MASK), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameters SHALL be:
- AW, 6: register address width (64 registers)
- DW, 32: data width
- OPW, 8: opcode passthrough width

REQ-002 Ports SHALL be:
- CLK, in, 1: sole clock, rising edge
- RST, in, 1: asynchronous, active-high reset
- IN_VALID, in, 1: decoded instruction present
- IN_READY, out, 1: stage accepts the instruction this cycle
- IN_SRA, in, AW: source A register
- IN_SRB, in, AW: source B register
- IN_DR, in, AW: destination register
- IN_WEN, in, 1: instruction writes IN_DR
- IN_OP, in, OPW: opcode, passed through
- SRA, out, AW: register-bank read address A, equal to IN_SRA combinationally
- SRB, out, AW: register-bank read address B, equal to IN_SRB combinationally
- RE_A, in, DW: register-bank read data A
- RE_B, in, DW: register-bank read data B
- WB_EN, in, 1: writeback commits this cycle
- WB_DR, in, AW: writeback destination
- WB_WD, in, DW: writeback data
- OUT_VALID, out, 1: operand bundle valid
- OUT_READY, in, 1: execute stage accepts the bundle
- OUT_A, OUT_B, out, DW: resolved operands
- OUT_DR, out, AW: registered IN_DR
- OUT_WEN, out, 1: registered IN_WEN
- OUT_OP, out, OPW: registered IN_OP
- BUSY_MASK, out, 2**AW: scoreboard pending bits

Function
REQ-003 The stage SHALL hold one output register slot, which is either EMPTY (OUT_VALID=0) or FULL (OUT_VALID=1).
REQ-004 The slot SHALL be free when OUT_VALID=0 or OUT_READY=1.
REQ-005 A source SHALL be hazarded when BUSY_MASK[src]=1 and not (WB_EN and WB_DR==src).
REQ-006 A WAW hazard SHALL exist when IN_WEN=1, BUSY_MASK[IN_DR]=1, and not (WB_EN and WB_DR==IN_DR).
REQ-007 IN_READY SHALL be 1 exactly when the slot is free and there is no hazard on SRA, no hazard on SRB, and no WAW hazard.
REQ-008 IN_READY SHALL be independent of IN_VALID.
REQ-009 Issue SHALL occur when IN_VALID and IN_READY are both 1. On issue, at the next edge, OUT_VALID<=1 and OUT_DR/OUT_WEN/OUT_OP are loaded from IN_*.
REQ-010 On issue, OUT_A SHALL be loaded with WB_WD if WB_EN and WB_DR==IN_SRA, else with RE_A. OUT_B SHALL follow the same rule using IN_SRB and RE_B.
REQ-011 When the slot is free and no issue occurs, OUT_VALID SHALL go to 0 at the next edge.
REQ-012 When OUT_VALID=1 and OUT_READY=0, all OUT_* outputs SHALL hold their values.
REQ-013 Issue-to-OUT_VALID latency SHALL be 1 cycle. Back-to-back issue SHALL be possible while OUT_READY=1, giving throughput of 1 per cycle.
REQ-014 Scoreboard updates at each edge SHALL be:
- Clear: WB_EN clears BUSY_MASK[WB_DR].
- Set: issue with IN_WEN=1 sets BUSY_MASK[IN_DR].
- If set and clear target the same register in the same cycle, set SHALL win (bit ends at 1).
REQ-015 WB_EN with WB_DR not pending SHALL be harmless: the bit stays 0 and no error is raised.
REQ-016 IN_SRA==IN_SRB SHALL be legal, and both operands SHALL resolve identically.
REQ-017 An instruction whose IN_DR equals its own source SHALL issue only when that source is not hazarded. It SHALL then set the bit for its destination.
REQ-018 IN_* inputs held while IN_READY=0 SHALL NOT alter any state.

Reset
REQ-019 On RST assertion, without waiting for a clock edge, outputs SHALL be:
- OUT_VALID=0
- BUSY_MASK=0
- OUT_A, OUT_B, OUT_DR, OUT_WEN, OUT_OP = 0
REQ-020 RST asserted mid-operation SHALL discard the held bundle and all pending bits.
REQ-021 While RST=1, IN_READY SHALL be 0.
REQ-022 The first issue after reset SHALL be possible in the first cycle after RST deasserts.

Verification
REQ-023 Basic issue: after reset, issue SRA=3, SRB=4, DR=5, WEN=1, RE_A=0x11, RE_B=0x22, OUT_READY=1. Next cycle: OUT_VALID=1, OUT_A=0x11, OUT_B=0x22, OUT_DR=5, BUSY_MASK[5]=1.
REQ-024 RAW stall then bypass: with r5 pending, present SRA=5, WB_EN=0. Required: IN_READY=0 for 3 cycles. Then WB_EN=1, WB_DR=5, WB_WD=0xCAFE: IN_READY=1 that cycle, OUT_A=0xCAFE next cycle, BUSY_MASK[5]=0.
REQ-025 Backpressure: with OUT_VALID=1, hold OUT_READY=0 for 4 cycles. Required: IN_READY=0 and OUT_* stable throughout. Raise OUT_READY: the next instruction issues the same cycle.
REQ-026 WAW and simultaneous set/clear: with r7 pending, present DR=7, WEN=1. Required: stall. Then assert WB_EN, WB_DR=7 in the same cycle as issue: BUSY_MASK[7]=1 afterwards.
REQ-027 Reset mid-flight: with OUT_VALID=1 and BUSY_MASK=0x...A0, assert RST between clock edges. Required: OUT_VALID=0 and BUSY_MASK=0 immediately, and IN_READY=0 until release.
